// File: rtl/cs_seq.sv
// cs_seq: frame sequencer for a WIN-deep sliding-window datapath (fill, run, flush).
// Rev 1.0
`default_nettype none

module cs_seq #(
  parameter int WIN = 9,
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] cs_x,
  output logic       cs_shift,
  output logic       cs_clear,
  input  logic [9:0] cs_y,
  output logic       out_valid,
  output logic [9:0] out_data,
  output logic       out_last,
  output logic       short_frame,
  output logic       busy
);

  localparam int CW = $clog2(WIN + 1);
  localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [CW-1:0] WIN_C   = CW'(WIN);
  localparam logic [CW-1:0] WIN_M1  = CW'(WIN - 1);
  localparam logic [FW-1:0] FLUSH_E = FW'(LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]     state;
  logic [1:0]     next_state;
  logic [CW-1:0]  fill_cnt;
  logic [FW-1:0]  flush_cnt;
  logic [LAT-1:0] full_pipe;
  logic [LAT-1:0] last_pipe;
  logic           accept;
  logic           reach_win;
  logic           flush_done;
  logic           short_det;

  // reach_win: this acceptance makes the WIN-th (or later) sample of the frame
  assign accept     = in_valid & in_ready;
  assign reach_win  = (fill_cnt >= WIN_M1);
  assign flush_done = (state == S_FLUSH) && (flush_cnt == FLUSH_E);
  assign short_det  = accept & in_last & ~reach_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) next_state = in_last ? S_FLUSH : S_FILL;
      end
      S_FILL: begin
        if (accept && in_last)        next_state = S_FLUSH;
        else if (accept && reach_win) next_state = S_RUN;
      end
      S_RUN: begin
        if (accept && in_last) next_state = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_done) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Reset gates the combinational handshake so nothing is offered while held.
  always_comb begin
    in_ready = ~reset && (state != S_FLUSH);
    cs_shift = in_valid & in_ready;
    cs_x     = in_data;
    cs_clear = ~reset & flush_done;
    busy     = ~reset && (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt <= '0;
    end else if (flush_done) begin
      fill_cnt <= '0;
    end else if (accept && (fill_cnt != WIN_C)) begin
      fill_cnt <= fill_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= '0;
    end else if ((state == S_FLUSH) && !flush_done) begin
      flush_cnt <= flush_cnt + FW'(1);
    end else begin
      flush_cnt <= '0;
    end
  end

  // Tags ride alongside the datapath so out_valid lines up with cs_y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_pipe <= '0;
      last_pipe <= '0;
    end else begin
      full_pipe[0] <= accept & reach_win;
      last_pipe[0] <= accept & in_last;
      for (int i = 1; i < LAT; i++) begin
        full_pipe[i] <= full_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      short_frame <= 1'b0;
    end else begin
      short_frame <= short_det;
    end
  end

  always_comb begin
    out_valid = full_pipe[LAT-1];
    out_last  = full_pipe[LAT-1] & last_pipe[LAT-1];
    out_data  = full_pipe[LAT-1] ? cs_y : 10'd0;
  end

endmodule

`default_nettype wire

// File: tb/tb_cs_seq.sv
// tb_cs_seq: directed checks of cs_seq framing with WIN=9, LAT=1.
`default_nettype none

module tb_cs_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] cs_x;
  logic       cs_shift;
  logic       cs_clear;
  logic [9:0] cs_y;
  logic       out_valid;
  logic [9:0] out_data;
  logic       out_last;
  logic       short_frame;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int pulses;

  cs_seq #(.WIN(9), .LAT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .cs_x       (cs_x),
    .cs_shift   (cs_shift),
    .cs_clear   (cs_clear),
    .cs_y       (cs_y),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .short_frame(short_frame),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then settle to mid-cycle for checks.
  task automatic cyc(input logic v, input logic [7:0] d, input logic l);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    cyc_n++;
    cs_y     = 10'((cyc_n * 37 + 5) % 1024);
    #4;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic l);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".out_last"},  32'(out_last),  32'(l));
    check({tag, ".out_data"},  32'(out_data),  v ? 32'(cs_y) : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b0;
    cs_y     = 10'h3ff;

    // Reset held for two cycles with a sample offered.
    repeat (2) begin
      @(posedge clk);
      #5;
      check("rst.in_ready", 32'(in_ready), 32'd0);
      check("rst.cs_shift", 32'(cs_shift), 32'd0);
      check("rst.cs_clear", 32'(cs_clear), 32'd0);
      check("rst.short",    32'(short_frame), 32'd0);
      check("rst.busy",     32'(busy), 32'd0);
      chk_out("rst", 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    #4;
    check("rel.in_ready", 32'(in_ready), 32'd1);
    check("rel.busy",     32'(busy), 32'd0);

    // 12 contiguous samples, last on the 12th.
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 8'(i), i == 12);
      check("t2.cs_shift", 32'(cs_shift), 32'd1);
      check("t2.cs_x",     32'(cs_x), 32'(i));
      chk_out("t2", i >= 10, 1'b0);
      pulses += int'(out_valid);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk_out("t2.end", 1'b1, 1'b1);
    pulses += int'(out_valid);
    check("t2.flush_ready", 32'(in_ready), 32'd0);
    check("t2.cs_clear",    32'(cs_clear), 32'd1);
    check("t2.flush_busy",  32'(busy), 32'd1);
    check("t2.pulses",      32'(pulses), 32'd4);
    cyc(1'b0, 8'h00, 1'b0);
    check("t2.idle_busy",  32'(busy), 32'd0);
    check("t2.idle_ready", 32'(in_ready), 32'd1);
    check("t2.idle_clear", 32'(cs_clear), 32'd0);
    chk_out("t2.idle", 1'b0, 1'b0);

    // Short frame of 5 samples.
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 8'(i + 32), i == 5);
      chk_out("t3", 1'b0, 1'b0);
      check("t3.short_lo", 32'(short_frame), 32'd0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    check("t3.short_hi", 32'(short_frame), 32'd1);
    check("t3.cs_clear", 32'(cs_clear), 32'd1);
    check("t3.in_ready", 32'(in_ready), 32'd0);
    chk_out("t3.flush", 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t3.short_end", 32'(short_frame), 32'd0);
    check("t3.busy_end",  32'(busy), 32'd0);

    // Nine samples with a three-cycle gap after the 4th.
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 8'(i + 64), 1'b0);
      chk_out("t4.a", 1'b0, 1'b0);
    end
    repeat (3) begin
      cyc(1'b0, 8'h00, 1'b0);
      check("t4.gap_shift", 32'(cs_shift), 32'd0);
      check("t4.gap_busy",  32'(busy), 32'd1);
      chk_out("t4.gap", 1'b0, 1'b0);
    end
    for (int i = 5; i <= 9; i++) begin
      cyc(1'b1, 8'(i + 64), i == 9);
      chk_out("t4.b", 1'b0, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk_out("t4.end", 1'b1, 1'b1);
    check("t4.cs_clear", 32'(cs_clear), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk_out("t4.idle", 1'b0, 1'b0);
    check("t4.idle_busy", 32'(busy), 32'd0);

    // Reset after the 10th sample of a running frame.
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 8'(i + 96), 1'b0);
      chk_out("t5.a", i >= 10, 1'b0);
    end
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    #4;
    check("t5.rst_valid", 32'(out_valid), 32'd0);
    check("t5.rst_last",  32'(out_last), 32'd0);
    check("t5.rst_busy",  32'(busy), 32'd0);
    check("t5.rst_short", 32'(short_frame), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #4;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 8'(i + 128), i == 10);
      chk_out("t5.b", i >= 10, 1'b0);
      check("t5.short", 32'(short_frame), 32'd0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk_out("t5.end", 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk_out("t5.idle", 1'b0, 1'b0);

    // in_valid held high through FLUSH.
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 8'(i + 160), i == 9);
      chk_out("t6.a", 1'b0, 1'b0);
    end
    cyc(1'b1, 8'hAA, 1'b0);
    check("t6.flush_shift", 32'(cs_shift), 32'd0);
    check("t6.flush_ready", 32'(in_ready), 32'd0);
    chk_out("t6.flush", 1'b1, 1'b1);
    cyc(1'b1, 8'hB1, 1'b0);
    check("t6.next_shift", 32'(cs_shift), 32'd1);
    check("t6.next_ready", 32'(in_ready), 32'd1);
    check("t6.next_busy",  32'(busy), 32'd0);
    chk_out("t6.next", 1'b0, 1'b0);
    for (int i = 2; i <= 9; i++) begin
      cyc(1'b1, 8'(i + 176), i == 9);
      chk_out("t6.b", 1'b0, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk_out("t6.end", 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk_out("t6.idle", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
